// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
//   UART receiver. Oversamples RX_IN at CLK, detects the start bit, then
//   deserializes DATA_WIDTH bits LSB first, an optional parity bit and one
//   stop bit. A good frame produces a one-cycle data_valid pulse together
//   with the new P_DATA word. Parity and stop problems produce one-cycle
//   par_err / stp_err pulses instead, and P_DATA keeps its previous value.
//
// Ports
//   CLK        oversampling clock
//   RST        asynchronous reset, active low
//   RX_IN      serial line, idle high, already synchronous to CLK
//   Prescale   oversampling ratio (8, 16 or 32), latched at start detection
//   PAR_EN     parity bit present after the data bits (latched per frame)
//   PAR_TYP    0 = even parity, 1 = odd parity (latched per frame)
//   P_DATA     last good received word
//   data_valid one-cycle pulse, P_DATA updated
//   par_err    one-cycle pulse, parity mismatch
//   stp_err    one-cycle pulse, stop bit sampled low
//
// Configuration
//   UART_RX_MAJORITY_VOTE_EN  when defined, every bit is the 2-of-3 majority
//   of the samples at Prescale/2-1, Prescale/2 and Prescale/2+1, decided at
//   Prescale/2+1. When undefined, one sample at Prescale/2 decides the bit.
// -----------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int                    BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0]        LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    par_bad_q, par_bad_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q, par_err_d;
    logic                    stp_err_q, stp_err_d;

    logic [PRESCALE_W-1:0]   half_pt;
    logic                    bit_end;
    logic                    dec_pt;
    logic                    bit_val;
    logic                    start_now;

    assign half_pt = prescale_q >> 1;

    // ">=" rather than "==" so an illegal ratio (0, odd, tiny) can never
    // strand the counter past its terminal value.
    assign bit_end = (edge_cnt_q >= (prescale_q - ONE));

    // A start bit is recognised in IDLE, and also in the last STOP cycle so
    // back-to-back frames keep exactly one frame period between them.
    assign start_now = ((state_q == S_IDLE) && !RX_IN) ||
                       ((state_q == S_STOP) && bit_end && !RX_IN);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic smp_early_q, smp_early_d;
    logic smp_mid_q, smp_mid_d;

    // The third vote is the live line value at the decision point.
    assign dec_pt  = (edge_cnt_q == (half_pt + ONE));
    assign bit_val = (smp_early_q & smp_mid_q) |
                     (smp_early_q & RX_IN) |
                     (smp_mid_q & RX_IN);

    always_comb begin
        smp_early_d = smp_early_q;
        smp_mid_d   = smp_mid_q;
        if (edge_cnt_q == (half_pt - ONE)) begin
            smp_early_d = RX_IN;
        end
        if (edge_cnt_q == half_pt) begin
            smp_mid_d = RX_IN;
        end
    end

    always_ff @(posedge CLK) begin
        smp_early_q <= smp_early_d;
        smp_mid_q   <= smp_mid_d;
    end
`else
    assign dec_pt  = (edge_cnt_q == half_pt);
    assign bit_val = RX_IN;
`endif

    // State register and control/output flops
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    // The payload shifter is fully rewritten by every frame before it is used.
    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!RX_IN) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // A start bit that reads high at its centre was a glitch.
                if (dec_pt && bit_val) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_cnt_q == LAST_BIT)) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = RX_IN ? S_IDLE : S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, per-frame configuration and payload shifter
    always_comb begin
        edge_cnt_d = edge_cnt_q + ONE;
        bit_cnt_d  = bit_cnt_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        shift_d    = shift_q;

        if ((state_d == S_IDLE) || start_now || bit_end) begin
            edge_cnt_d = '0;
        end

        if (state_q != S_DATA) begin
            bit_cnt_d = '0;
        end else if (bit_end) begin
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BCW'(1);
        end

        if (start_now) begin
            prescale_d = Prescale;
            par_en_d   = PAR_EN;
            par_typ_d  = PAR_TYP;
        end

        // Right shift: after DATA_WIDTH bits the first bit received sits in
        // bit 0, i.e. LSB-first ordering.
        if ((state_q == S_DATA) && dec_pt) begin
            shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
        end
    end

    // Output logic: parity tracking and the end-of-frame pulses
    always_comb begin
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (start_now) begin
            par_bad_d = 1'b0;
        end

        if ((state_q == S_PARITY) && dec_pt) begin
            par_bad_d = (bit_val != ((^shift_q) ^ par_typ_q));
        end

        if ((state_q == S_STOP) && dec_pt) begin
            stp_err_d = !bit_val;
            par_err_d = par_bad_q;
            if (bit_val && !par_bad_q) begin
                data_valid_d = 1'b1;
                p_data_d     = shift_q;
            end
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
//   Directed and randomized frames for uart_rx_frame. Each frame sent is also
//   handed to a frame-level reference model that predicts the outcome pulse,
//   its cycle and the P_DATA value; a monitor records what the DUT produced.
//   Honours UART_RX_MAJORITY_VOTE_EN when defined for the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int MV = 1;
`else
    localparam int MV = 0;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          rx      = 1'b1;
    logic [PW-1:0] presc   = PW'(8);
    logic          par_en  = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] p_data;
    logic          dv, pe, se;

    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] held   = '0;

    typedef struct {
        int            c;
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] pd;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .RX_IN      (rx),
        .Prescale   (presc),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .data_valid (dv),
        .par_err    (pe),
        .stp_err    (se)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with any outcome pulse is logged, so stretched pulses show
    // up as extra events.
    always @(negedge clk) begin
        if (rst_n && (dv || pe || se)) begin
            got_q.push_back('{c: cyc, dv: dv, pe: pe, se: se, pd: p_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Frame-level model: the line was driven low first at cycle s, so the
    // DUT registers the start at s+1 and reports Prescale*(1+DW+PAR_EN) +
    // Prescale/2 + 1 (+1 with majority vote) cycles later.
    function automatic void model_frame(input int s, input int p, input bit pen, input bit ptyp,
                                        input logic [DW-1:0] d, input bit pbit, input bit stopb);
        ev_t e;
        bit  perr;
        bit  serr;
        int  lat;
        perr = pen && (pbit != ((^d) ^ ptyp));
        serr = !stopb;
        lat  = p * (1 + DW + (pen ? 1 : 0)) + p / 2 + 1 + MV;
        if (!perr && !serr) held = d;
        e.c  = s + 1 + lat;
        e.dv = !perr && !serr;
        e.pe = perr;
        e.se = serr;
        e.pd = held;
        exp_q.push_back(e);
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge. inv_off >= 0 inverts that line cycle inside every
    // data bit. Configuration inputs are scrambled after the start bit to
    // show they are only taken at start detection.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [DW-1:0] d,
                              input bit flip, input bit stopb, input int inv_off);
        logic bits[$];
        logic b;
        bit   pbit;
        pbit = (^d) ^ ptyp ^ flip;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(stopb);
        presc   = PW'(p);
        par_en  = pen;
        par_typ = ptyp;
        model_frame(cyc, p, pen, ptyp, d, pbit, stopb);
        for (int j = 0; j < bits.size(); j++) begin
            for (int k = 0; k < p; k++) begin
                b = bits[j];
                if (inv_off >= 0 && j >= 1 && j <= DW && k == inv_off) b = ~b;
                if (j == 1 && k == 0) begin
                    presc   = PW'(8 << $urandom_range(0, 2));
                    par_en  = 1'($urandom_range(0, 1));
                    par_typ = 1'($urandom_range(0, 1));
                end
                rx = b;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_events(input string tag);
        int n;
        chk({tag, " count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, " cycle"}, got_q[i].c, exp_q[i].c);
            chk({tag, " flags"}, {got_q[i].dv, got_q[i].pe, got_q[i].se},
                {exp_q[i].dv, exp_q[i].pe, exp_q[i].se});
            chk({tag, " pdata"}, got_q[i].pd, exp_q[i].pd);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int p, gap;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset dv/pe/se", {dv, pe, se}, 3'b000);
        chk("reset pdata", p_data, 8'h00);
        rst_n = 1'b1;
        idle(5);

        // Prescale 8, no parity, 0xA5
        send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1);
        idle(12);
        check_events("a5");

        // Prescale 16, even parity: good then corrupted parity
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1);
        idle(20);
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1);
        idle(20);
        check_events("par16");
        send_frame(16, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1, -1);
        idle(20);
        send_frame(16, 1'b1, 1'b1, 8'h42, 1'b1, 1'b1, -1);
        idle(20);
        check_events("parhold");
        chk("pdata hold after par_err", p_data, 8'h99);

        // Prescale 32, odd parity, stop bit low
        send_frame(32, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, -1);
        idle(40);
        check_events("stop32");

        // Start glitch, then a valid frame
        presc = PW'(16);
        rx = 1'b0;
        repeat (7) @(negedge clk);
        idle(16);
        send_frame(16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, -1);
        idle(20);
        check_events("glitch");

        // Back-to-back frames, no idle gap
        send_frame(8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, -1);
        send_frame(8, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, -1);
        idle(12);
        if (got_q.size() >= 2) chk("b2b spacing", got_q[1].c - got_q[0].c, 80);
        check_events("b2b");

        // Reset in the middle of DATA of 0x77, then frame 0x12
        presc = PW'(8);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset dv/pe/se", {dv, pe, se}, 3'b000);
        chk("midreset pdata", p_data, 8'h00);
        rst_n = 1'b1;
        held = '0;
        idle(20);
        send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, -1);
        idle(12);
        check_events("reset");

        // A one-cycle inversion away from the sample window is ignored
        send_frame(16, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1);
        idle(20);
        check_events("offglitch");

`ifdef UART_RX_MAJORITY_VOTE_EN
        // Inversion on the centre sample of each data bit is out-voted. The
        // DUT reads the line one cycle after the edge count it is in, so the
        // centre sample is line offset Prescale/2+1 within the bit.
        send_frame(8, 1'b0, 1'b0, 8'h6D, 1'b0, 1'b1, 8 / 2 + 1);
        idle(12);
        send_frame(16, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 16 / 2 + 1);
        idle(20);
        check_events("vote");
`endif

        // Randomized frames with random gaps (including none)
        for (int n = 0; n < 24; n++) begin
            p   = 8 << $urandom_range(0, 2);
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, p));
            send_frame(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), -1);
            if (gap > 0) idle(gap);
        end
        idle(40);
        check_events("rand");
        chk("final pdata", p_data, held);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
